// File: rtl/nco_sine_dacmux.sv
// nco_sine_dacmux: 16-bit phase-accumulator NCO, 256-entry sine LUT and composite-video DAC level mux.
// Define DACMUX_REG_OUT_EN to register toDAC (one extra cycle of latency, resets to the blank level).
module nco_sine_dacmux (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fcw,
  input  logic [7:0]  active,
  input  logic [2:0]  state,
  output logic [7:0]  phase,
  output logic [7:0]  colourb,
  output logic [7:0]  toDAC
);
  localparam int unsigned ACC_W = 16;
  localparam int unsigned PH_W  = 8;
  localparam int unsigned SMP_W = 8;
  localparam int unsigned Q_W   = 7;

  localparam logic [SMP_W-1:0] LVL_MID   = 8'd128;
  localparam logic [SMP_W-1:0] LVL_SYNC  = 8'h00;
  localparam logic [SMP_W-1:0] LVL_BLANK = 8'h40;

  logic [ACC_W-1:0] r_acc;
  logic [SMP_W-1:0] r_colourb;
  logic [Q_W-1:0]   w_q_idx;
  logic [Q_W-1:0]   w_q_mag;
  logic [SMP_W-1:0] w_sine;
  logic [SMP_W-1:0] w_dac;

  // round(127*sin(pi*k/128)) for k = 0..64; the full wave is rebuilt by symmetry
  function automatic logic [6:0] quarter_sine(input logic [6:0] k);
    logic [6:0] v;
    v = 7'd0;
    case (k)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
      7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
      7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      7'd64: v = 7'd127;
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  assign phase = r_acc[ACC_W-1 -: PH_W];

  // Quadrant 1/3 walk the quarter table backwards; the upper half is negative
  always_comb begin
    w_q_idx = Q_W'(phase[5:0]);
    if (phase[6]) begin
      w_q_idx = 7'd64 - Q_W'(phase[5:0]);
    end
    w_q_mag = quarter_sine(w_q_idx);
    w_sine  = phase[7] ? (LVL_MID - SMP_W'(w_q_mag)) : (LVL_MID + SMP_W'(w_q_mag));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_colourb <= LVL_MID;
    end else begin
      r_acc     <= r_acc + fcw;
      r_colourb <= w_sine;
    end
  end

  assign colourb = r_colourb;

  always_comb begin
    w_dac = LVL_BLANK;
    case (state)
      3'd0:    w_dac = LVL_SYNC;
      3'd2:    w_dac = r_colourb;
      3'd3:    w_dac = active;
      default: w_dac = LVL_BLANK;
    endcase
  end

`ifdef DACMUX_REG_OUT_EN
  logic [SMP_W-1:0] r_dac;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dac <= LVL_BLANK;
    end else begin
      r_dac <= w_dac;
    end
  end

  assign toDAC = r_dac;
`else
  assign toDAC = w_dac;
`endif

endmodule

// File: tb/tb_nco_sine_dacmux.sv
// Bench for nco_sine_dacmux: reference model pushes expected phase/colourb/toDAC per edge, tests pop and compare.
`timescale 1ns/1ps
module tb_nco_sine_dacmux;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fcw;
  logic [7:0]  active;
  logic [2:0]  state;
  logic [7:0]  phase;
  logic [7:0]  colourb;
  logic [7:0]  toDAC;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_acc;
  logic [7:0]  m_col;
  logic [7:0]  m_dac;
  logic [7:0]  q_ph[$];
  logic [7:0]  q_col[$];
  logic [7:0]  q_dac[$];
  logic [7:0]  e_ph, e_col, e_dac;

  nco_sine_dacmux dut (
    .clk     (clk),
    .reset   (reset),
    .fcw     (fcw),
    .active  (active),
    .state   (state),
    .phase   (phase),
    .colourb (colourb),
    .toDAC   (toDAC)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] lut_ref(input int k);
    real v;
    v = 128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * $itor(k) / 256.0);
    return 8'($rtoi(v + 0.5));
  endfunction

  function automatic logic [7:0] mux_ref(input logic [2:0] s, input logic [7:0] a, input logic [7:0] c);
    case (s)
      3'd0:    return 8'h00;
      3'd2:    return c;
      3'd3:    return a;
      default: return 8'h40;
    endcase
  endfunction

  // Advance the model by one edge, queue its expectations, clock the DUT, pop them for comparison
  task automatic cycle();
    logic [7:0] old_col;
    old_col = m_col;
    if (reset) begin
      m_acc = 16'd0;
      m_col = 8'd128;
    end else begin
      m_col = lut_ref(int'(m_acc[15:8]));
      m_acc = m_acc + fcw;
    end
`ifdef DACMUX_REG_OUT_EN
    m_dac = reset ? 8'h40 : mux_ref(state, active, old_col);
`else
    m_dac = mux_ref(state, active, m_col);
`endif
    q_ph.push_back(m_acc[15:8]);
    q_col.push_back(m_col);
    q_dac.push_back(m_dac);
    @(posedge clk);
    #1;
    e_ph  = q_ph.pop_front();
    e_col = q_col.pop_front();
    e_dac = q_dac.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1; fcw = 16'd4692; active = 8'd0; state = 3'd2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (phase !== 8'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
      checks++; if (colourb !== 8'd128) begin errors++; $display("FAIL reset_colourb got=%0d exp=128", colourb); end
      checks++; if (toDAC !== e_dac) begin errors++; $display("FAIL reset_todac got=%0d exp=%0d", toDAC, e_dac); end
    end
  endtask

  task automatic test_step();
    logic [7:0] exp_ph [3];
    exp_ph = '{8'd18, 8'd36, 8'd54};
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL step_phase[%0d] got=%0d exp=%0d", i, phase, exp_ph[i]); end
      checks++; if (colourb !== e_col) begin errors++; $display("FAIL step_colourb[%0d] got=%0d exp=%0d", i, colourb, e_col); end
      checks++; if (toDAC !== e_dac) begin errors++; $display("FAIL step_todac[%0d] got=%0d exp=%0d", i, toDAC, e_dac); end
    end
  endtask

  task automatic test_quadrants();
    logic [7:0] exp_ph [6];
    logic [7:0] exp_col [6];
    exp_ph  = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64};
    exp_col = '{8'd128, 8'd128, 8'd255, 8'd128, 8'd1, 8'd128};
    reset = 1'b1; fcw = 16'd16384;
    for (int i = 0; i < 6; i++) begin
      cycle();
      reset = 1'b0;
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL quad_phase[%0d] got=%0d exp=%0d", i, phase, exp_ph[i]); end
      checks++; if (colourb !== exp_col[i]) begin errors++; $display("FAIL quad_colourb[%0d] got=%0d exp=%0d", i, colourb, exp_col[i]); end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1; fcw = 16'hFFFF;
    cycle();
    reset = 1'b0;
    cycle();
    checks++; if (phase !== 8'hFF) begin errors++; $display("FAIL wrap_preload got=%0d exp=255", phase); end
    fcw = 16'd1;
    cycle();
    checks++; if (phase !== 8'h00) begin errors++; $display("FAIL wrap_phase got=%0d exp=0", phase); end
    checks++; if (colourb !== e_col) begin errors++; $display("FAIL wrap_colourb got=%0d exp=%0d", colourb, e_col); end
  endtask

  task automatic test_mux_sweep();
    logic [7:0] exp_dac [8];
    exp_dac = '{8'd0, 8'd64, 8'd255, 8'd200, 8'd64, 8'd64, 8'd64, 8'd64};
    reset = 1'b1; fcw = 16'd16384; active = 8'd200; state = 3'd1;
    cycle();
    reset = 1'b0;
    cycle();
    fcw = 16'd0;
    cycle();
    checks++; if (colourb !== 8'd255) begin errors++; $display("FAIL sweep_setup got=%0d exp=255", colourb); end
    for (int s = 0; s < 8; s++) begin
      state = 3'(s);
      cycle();
      checks++; if (toDAC !== exp_dac[s]) begin errors++; $display("FAIL sweep_state%0d got=%0d exp=%0d", s, toDAC, exp_dac[s]); end
      checks++; if (phase !== 8'd64) begin errors++; $display("FAIL sweep_hold_phase got=%0d exp=64", phase); end
      checks++; if (toDAC !== e_dac) begin errors++; $display("FAIL sweep_model%0d got=%0d exp=%0d", s, toDAC, e_dac); end
    end
  endtask

  task automatic test_dac_latency();
    logic [7:0] exp_now;
    state = 3'd3; active = 8'd200;
    cycle();
    checks++; if (toDAC !== 8'd200) begin errors++; $display("FAIL lat_active got=%0d exp=200", toDAC); end
    state = 3'd0;
    #1;
`ifdef DACMUX_REG_OUT_EN
    exp_now = 8'd200;
`else
    exp_now = 8'd0;
`endif
    checks++; if (toDAC !== exp_now) begin errors++; $display("FAIL lat_before_edge got=%0d exp=%0d", toDAC, exp_now); end
    cycle();
    checks++; if (toDAC !== 8'd0) begin errors++; $display("FAIL lat_after_edge got=%0d exp=0", toDAC); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0; fcw = 16'd4692; state = 3'd2;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (phase !== e_ph) begin errors++; $display("FAIL midrun_phase[%0d] got=%0d exp=%0d", i, phase, e_ph); end
    end
    reset = 1'b1;
    cycle();
    checks++; if (phase !== 8'd0) begin errors++; $display("FAIL midrst_phase got=%0d exp=0", phase); end
    checks++; if (colourb !== 8'd128) begin errors++; $display("FAIL midrst_colourb got=%0d exp=128", colourb); end
    reset = 1'b0;
    cycle();
    checks++; if (phase !== 8'd18) begin errors++; $display("FAIL midrst_resume1 got=%0d exp=18", phase); end
    cycle();
    checks++; if (phase !== 8'd36) begin errors++; $display("FAIL midrst_resume2 got=%0d exp=36", phase); end
    checks++; if (colourb !== e_col) begin errors++; $display("FAIL midrst_colourb2 got=%0d exp=%0d", colourb, e_col); end
  endtask

  task automatic test_lut_sweep();
    reset = 1'b1; fcw = 16'd256; state = 3'd2;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 258; i++) begin
      cycle();
      checks++; if (colourb !== e_col) begin errors++; $display("FAIL lut_colourb phase=%0d got=%0d exp=%0d", e_ph, colourb, e_col); end
      checks++; if (toDAC !== e_dac) begin errors++; $display("FAIL lut_todac got=%0d exp=%0d", toDAC, e_dac); end
    end
  endtask

  initial begin
    reset = 1'b1; fcw = 16'd0; active = 8'd0; state = 3'd0;
    test_reset();
    test_step();
    test_quadrants();
    test_wrap();
    test_mux_sweep();
    test_dac_latency();
    test_mid_reset();
    test_lut_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
